msrh_tlb_walk_req: RTL and testbench
====================================

# msrh_tlb_walk_req

Fully-associative translation cache that sits in front of a fetch or LSU pipeline and is the requesting end of the page-table-walk handshake. Requests hit in a small entry array. On a miss the block issues a single PTW request, waits for the leaf PTE, and refills the array. Faulting walks are held in a one-entry fault register so that the retried access reports a page fault.

## Interface
- ENTRIES, 8: number of TLB entries; power of two, minimum 2.
- VADDR_W, 39: virtual address width (Sv39).
- PADDR_W, 56: physical address width.
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_trans_en  in  1  1 = Sv39 translation; 0 = bare mode.
- i_req_valid  in  1  lookup request.
- i_req_vaddr  in  VADDR_W  virtual address.
- i_req_cmd  in  2  access type: 0 = load, 1 = store, 2 = fetch.
- o_resp_valid  out  1  lookup result valid.
- o_resp_miss  out  1  no translation present; requester retries.
- o_resp_pf  out  1  page fault.
- o_resp_paddr  out  PADDR_W  translated address; valid when hit and no fault.
- i_sfence_valid  in  1  flush all entries and the fault register.
- o_ptw_req_valid  out  1  walk request.
- o_ptw_req_vpn  out  27  VPN to walk.
- i_ptw_req_ready  in  1  walker accepts the request.
- i_ptw_resp_valid  in  1  walk result.
- i_ptw_resp_pte  in  64  Sv39 PTE: v=bit 0, r=1, w=2, x=3, ppn=[53:10].
- i_ptw_resp_level  in  2  2 = 1 GiB page, 1 = 2 MiB page, 0 = 4 KiB page.

## Operation
- Entry contents: valid, vpn[26:0], ppn[43:0], level[1:0], r/w/x.
- Match rule: compare vpn[26:18] always; compare vpn[17:9] when level ≤ 1; compare vpn[8:0] when level = 0.
- Physical address on a hit: {ppn, vaddr[11:0]}. For superpages, the lower PPN fields are replaced by VPN fields: level 1 takes ppn[8:0] from vpn[8:0]; level 2 takes ppn[17:0] from vpn[17:0].
- Permission fault on a hit: load with !r, store with !w, or fetch with !x gives resp_pf = 1 and miss = 0.
- Bare mode (i_trans_en = 0): always a hit, paddr = zero-extended vaddr, no fault, no walk.
- Fault register (valid + vpn): a lookup matching it at 4 KiB granularity gives pf = 1 and miss = 0. It takes priority over a miss.
- Walk FSM states: IDLE, REQ, WAIT.
- IDLE -> REQ: on a lookup miss that also misses the fault register. Latch that VPN.
- REQ: o_ptw_req_valid = 1 and vpn held stable. Move to WAIT on i_ptw_req_ready.
- WAIT -> IDLE: on i_ptw_resp_valid.
- Response handling in WAIT:
  - PTE is good (v = 1, leaf r|w|x, and not (w & !r)): refill one entry.
  - Otherwise: load the fault register with the walked VPN.
- A good refill clears the fault register if its VPN matches.
- Misses while in REQ or WAIT report miss = 1 and start no second walk.
- Victim selection: lowest-index invalid entry. If none is invalid, use the round-robin pointer, which increments modulo ENTRIES on each such refill.
- i_sfence_valid:
  - Clears all valid bits and the fault register.
  - In REQ, the FSM goes to IDLE and withdraws the request.
  - In WAIT, sets a kill flag. The next walk response is consumed, writes nothing, and the FSM goes to IDLE.

## Timing
- Reset values:
  - o_resp_valid, o_resp_miss, o_resp_pf, o_ptw_req_valid: 0.
  - o_resp_paddr, o_ptw_req_vpn: 0.
  - All entries invalid; fault register invalid; FSM in IDLE; round-robin pointer 0; kill flag 0.
- Reset asserted mid-walk drops the walk immediately. A walk response arriving after reset is ignored, because the FSM is in IDLE.
- Lookup latency is 1 cycle: a request in cycle N gives the resp_* outputs in cycle N+1, registered.
- A miss in cycle N puts o_ptw_req_valid high in cycle N+1.
- A refill on walk response cycle M is visible to lookups issued in cycle M+1 or later. A lookup issued in cycle M sees the old contents and misses.
- Simultaneous sfence and refill: sfence wins and nothing is written.
- Simultaneous sfence and lookup: the lookup uses the pre-flush contents.

## Test plan
- Basic walk and hit:
  - trans_en = 1, load vaddr 0x0000_1234 -> miss; ptw_req_vpn = 0x1 in the next cycle.
  - Respond pte.ppn = 0x80000, r = 1, level 0 -> retry hits with paddr 0x8000_0234.
- Superpage: 2 MiB leaf at level 1, ppn = 0x80200, for vaddr 0x0020_5678 -> paddr 0x8020_5678. Vaddr 0x003F_FFF0 also hits with no new walk.
- Faults:
  - Walk returns v = 0 -> retry gives pf = 1, miss = 0.
  - Store to a leaf with r = 1, w = 0 -> pf = 1.
  - sfence -> the same access misses again and a new walk is issued.
- Replacement: fill all 8 entries, then a 9th VPN -> entry 0 is evicted and its VPN misses. A 10th VPN evicts entry 1.
- Flush mid-walk: sfence in WAIT -> the following walk response writes nothing; the FSM returns to IDLE; the next miss issues a fresh walk.
- Concurrency and bare mode:
  - Second-VPN miss while in WAIT -> miss with no new o_ptw_req_valid.
  - trans_en = 0 -> paddr = vaddr with no walk.

Source files
------------

// File: rtl/msrh_tlb_walk_req.sv
// msrh_tlb_walk_req: fully-associative Sv39 translation cache that also acts as
// the requesting side of the page-table-walk handshake. A lookup miss launches
// one walk. The leaf PTE either refills an entry or loads a one-entry fault
// register, so that the retried access reports a page fault.
//
// PTW request handshake: o_ptw_req_valid rises in the cycle after the miss.
// o_ptw_req_vpn is held stable while valid is high. The request is consumed on
// the first rising clock edge where valid and i_ptw_req_ready are both high.
// The request is withdrawn only by an sfence. After that, exactly one
// i_ptw_resp_valid pulse is expected. A response that arrives while no walk is
// outstanding is ignored.
module msrh_tlb_walk_req #(
  parameter int ENTRIES = 8,
  parameter int VADDR_W = 39,
  parameter int PADDR_W = 56
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_trans_en,
  input  logic               i_req_valid,
  input  logic [VADDR_W-1:0] i_req_vaddr,
  input  logic [1:0]         i_req_cmd,
  output logic               o_resp_valid,
  output logic               o_resp_miss,
  output logic               o_resp_pf,
  output logic [PADDR_W-1:0] o_resp_paddr,
  input  logic               i_sfence_valid,
  output logic               o_ptw_req_valid,
  output logic [26:0]        o_ptw_req_vpn,
  input  logic               i_ptw_req_ready,
  input  logic               i_ptw_resp_valid,
  input  logic [63:0]        i_ptw_resp_pte,
  input  logic [1:0]         i_ptw_resp_level,
  output logic [1:0]         o_dbg_state
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [26:0]        walk_vpn_q, walk_vpn_d;
  logic               kill_q, kill_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               flt_valid_q, flt_valid_d;
  logic [26:0]        flt_vpn_q, flt_vpn_d;
  logic [ENTRIES-1:0] ent_valid_q, ent_valid_d;
  logic [26:0]        ent_vpn_q   [ENTRIES];
  logic [26:0]        ent_vpn_d   [ENTRIES];
  logic [43:0]        ent_ppn_q   [ENTRIES];
  logic [43:0]        ent_ppn_d   [ENTRIES];
  logic [1:0]         ent_level_q [ENTRIES];
  logic [1:0]         ent_level_d [ENTRIES];
  logic [2:0]         ent_rwx_q   [ENTRIES];  // {x, w, r}
  logic [2:0]         ent_rwx_d   [ENTRIES];
  logic               resp_valid_q, resp_valid_d;
  logic               resp_miss_q, resp_miss_d;
  logic               resp_pf_q, resp_pf_d;
  logic [PADDR_W-1:0] resp_paddr_q, resp_paddr_d;
  logic               ptw_req_valid_q, ptw_req_valid_d;

  logic [26:0]        req_vpn;
  logic [ENTRIES-1:0] ent_match;
  logic               hit, flt_hit, perm_ok, start_walk, any_free, pte_good;
  logic               refill, fault_load;
  logic [IDX_W-1:0]   hit_idx, free_idx, victim;
  logic [43:0]        eff_ppn;
  logic [2:0]         hit_rwx;
  logic               unused_pte_bits;

  assign req_vpn         = i_req_vaddr[38:12];
  assign flt_hit         = flt_valid_q && (flt_vpn_q == req_vpn);
  assign hit_rwx         = ent_rwx_q[hit_idx];
  assign pte_good        = i_ptw_resp_pte[0] && (|i_ptw_resp_pte[3:1]) &&
                           !(i_ptw_resp_pte[2] && !i_ptw_resp_pte[1]);
  assign victim          = any_free ? free_idx : rr_q;
  assign unused_pte_bits = ^{i_ptw_resp_pte[63:54], i_ptw_resp_pte[9:4]};

  // Per-entry match: upper VPN field always, lower fields only for smaller pages
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_match[i] = ent_valid_q[i] &&
                     (ent_vpn_q[i][26:18] == req_vpn[26:18]) &&
                     ((ent_level_q[i] >= 2'd2) || (ent_vpn_q[i][17:9] == req_vpn[17:9])) &&
                     ((ent_level_q[i] != 2'd0) || (ent_vpn_q[i][8:0] == req_vpn[8:0]));
    end
  end

  // Priority pick of the matching entry and of the first free slot (lowest index wins)
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!ent_valid_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Superpages take their low PPN fields from the VPN; permission check by access type
  always_comb begin
    case (ent_level_q[hit_idx])
      2'd0:    eff_ppn = ent_ppn_q[hit_idx];
      2'd1:    eff_ppn = {ent_ppn_q[hit_idx][43:9], req_vpn[8:0]};
      default: eff_ppn = {ent_ppn_q[hit_idx][43:18], req_vpn[17:0]};
    endcase
    case (i_req_cmd)
      2'd0:    perm_ok = hit_rwx[0];
      2'd1:    perm_ok = hit_rwx[1];
      2'd2:    perm_ok = hit_rwx[2];
      default: perm_ok = 1'b0;
    endcase
  end

  // Lookup result: bare pass-through, hit, fault-register hit, or miss
  always_comb begin
    resp_valid_d = i_req_valid;
    resp_miss_d  = 1'b0;
    resp_pf_d    = 1'b0;
    resp_paddr_d = '0;
    start_walk   = 1'b0;
    if (i_req_valid) begin
      if (!i_trans_en) begin
        resp_paddr_d = PADDR_W'(i_req_vaddr);
      end else if (hit) begin
        if (!perm_ok) resp_pf_d = 1'b1;
        else          resp_paddr_d = PADDR_W'({eff_ppn, i_req_vaddr[11:0]});
      end else if (flt_hit) begin
        resp_pf_d = 1'b1;
      end else begin
        resp_miss_d = 1'b1;
        start_walk  = (state_q == ST_IDLE);
      end
    end
  end

  // Walk FSM plus array/fault-register updates; sfence overrides any write
  always_comb begin
    state_d     = state_q;
    walk_vpn_d  = walk_vpn_q;
    kill_d      = kill_q;
    rr_d        = rr_q;
    flt_valid_d = flt_valid_q;
    flt_vpn_d   = flt_vpn_q;
    ent_valid_d = ent_valid_q;
    ent_vpn_d   = ent_vpn_q;
    ent_ppn_d   = ent_ppn_q;
    ent_level_d = ent_level_q;
    ent_rwx_d   = ent_rwx_q;
    refill      = 1'b0;
    fault_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_walk) begin
          state_d    = ST_REQ;
          walk_vpn_d = req_vpn;
        end
      end
      ST_REQ: begin
        if (i_sfence_valid)       state_d = ST_IDLE;
        else if (i_ptw_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ptw_resp_valid) begin
          state_d = ST_IDLE;
          kill_d  = 1'b0;
          if (!kill_q && !i_sfence_valid) begin
            if (pte_good) refill     = 1'b1;
            else          fault_load = 1'b1;
          end
        end else if (i_sfence_valid) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (refill) begin
      ent_valid_d[victim] = 1'b1;
      ent_vpn_d[victim]   = walk_vpn_q;
      ent_ppn_d[victim]   = i_ptw_resp_pte[53:10];
      ent_level_d[victim] = i_ptw_resp_level;
      ent_rwx_d[victim]   = i_ptw_resp_pte[3:1];
      if (!any_free) rr_d = rr_q + 1'b1;
      if (flt_valid_q && (flt_vpn_q == walk_vpn_q)) flt_valid_d = 1'b0;
    end
    if (fault_load) begin
      flt_valid_d = 1'b1;
      flt_vpn_d   = walk_vpn_q;
    end
    if (i_sfence_valid) begin
      ent_valid_d = '0;
      flt_valid_d = 1'b0;
    end
    ptw_req_valid_d = (state_d == ST_REQ);
  end

  // State, array and registered-output flops
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q         <= ST_IDLE;
      walk_vpn_q      <= '0;
      kill_q          <= 1'b0;
      rr_q            <= '0;
      flt_valid_q     <= 1'b0;
      flt_vpn_q       <= '0;
      ent_valid_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_vpn_q[i]   <= '0;
        ent_ppn_q[i]   <= '0;
        ent_level_q[i] <= '0;
        ent_rwx_q[i]   <= '0;
      end
      resp_valid_q    <= 1'b0;
      resp_miss_q     <= 1'b0;
      resp_pf_q       <= 1'b0;
      resp_paddr_q    <= '0;
      ptw_req_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      walk_vpn_q      <= walk_vpn_d;
      kill_q          <= kill_d;
      rr_q            <= rr_d;
      flt_valid_q     <= flt_valid_d;
      flt_vpn_q       <= flt_vpn_d;
      ent_valid_q     <= ent_valid_d;
      ent_vpn_q       <= ent_vpn_d;
      ent_ppn_q       <= ent_ppn_d;
      ent_level_q     <= ent_level_d;
      ent_rwx_q       <= ent_rwx_d;
      resp_valid_q    <= resp_valid_d;
      resp_miss_q     <= resp_miss_d;
      resp_pf_q       <= resp_pf_d;
      resp_paddr_q    <= resp_paddr_d;
      ptw_req_valid_q <= ptw_req_valid_d;
    end
  end

  assign o_resp_valid    = resp_valid_q;
  assign o_resp_miss     = resp_miss_q;
  assign o_resp_pf       = resp_pf_q;
  assign o_resp_paddr    = resp_paddr_q;
  assign o_ptw_req_valid = ptw_req_valid_q;
  assign o_ptw_req_vpn   = walk_vpn_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_msrh_tlb_walk_req.sv
// Testbench for msrh_tlb_walk_req: directed scenarios followed by random traffic,
// all scored against a page-size-arithmetic reference model.
module tb_msrh_tlb_walk_req;
  localparam int ENTRIES = 8;
  localparam int VADDR_W = 39;
  localparam int PADDR_W = 56;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               trans_en = 1'b1;
  logic               req_valid = 1'b0;
  logic [VADDR_W-1:0] vaddr = '0;
  logic [1:0]         cmd = '0;
  logic               sfence = 1'b0;
  logic               ready = 1'b0;
  logic               resp_valid = 1'b0;
  logic [63:0]        pte = '0;
  logic [1:0]         resp_level = '0;
  logic               o_resp_valid, o_resp_miss, o_resp_pf, o_ptw_req_valid;
  logic [PADDR_W-1:0] o_resp_paddr;
  logic [26:0]        o_ptw_req_vpn;
  logic [1:0]         o_dbg_state;

  msrh_tlb_walk_req #(.ENTRIES(ENTRIES), .VADDR_W(VADDR_W), .PADDR_W(PADDR_W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_trans_en(trans_en),
    .i_req_valid(req_valid), .i_req_vaddr(vaddr), .i_req_cmd(cmd),
    .o_resp_valid(o_resp_valid), .o_resp_miss(o_resp_miss), .o_resp_pf(o_resp_pf),
    .o_resp_paddr(o_resp_paddr), .i_sfence_valid(sfence),
    .o_ptw_req_valid(o_ptw_req_valid), .o_ptw_req_vpn(o_ptw_req_vpn),
    .i_ptw_req_ready(ready), .i_ptw_resp_valid(resp_valid),
    .i_ptw_resp_pte(pte), .i_ptw_resp_level(resp_level), .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model ----------------
  bit          m_v   [ENTRIES];
  logic [26:0] m_vpn [ENTRIES];
  logic [43:0] m_ppn [ENTRIES];
  int          m_lvl [ENTRIES];
  logic [2:0]  m_rwx [ENTRIES];   // {x, w, r}
  int          m_rr;
  bit          m_fv;
  logic [26:0] m_fvpn;
  int          m_st;              // 0 idle, 1 request outstanding, 2 waiting for PTE
  bit          m_kill;
  logic [26:0] m_wvpn;

  int checks = 0;
  int failures = 0;
  logic [58:0] exp_q[$];          // {valid, miss, pf, paddr}

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
    m_rr = 0; m_fv = 1'b0; m_fvpn = '0; m_st = 0; m_kill = 1'b0; m_wvpn = '0;
  endtask

  // Translation computed from page size: a level-L page spans 4 KiB << 9L.
  function automatic void model_lookup(input logic [38:0] va, input logic [1:0] c, input bit ten,
                                       output bit miss, output bit pf, output logic [55:0] pa);
    logic [26:0] vpn;
    logic [55:0] mask;
    int sh;
    bit ok;
    vpn = va[38:12];
    miss = 1'b0; pf = 1'b0; pa = '0;
    if (!ten) begin
      pa = 56'(va);
      return;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_v[i]) begin
        sh = 9 * m_lvl[i];
        if ((vpn >> sh) == (m_vpn[i] >> sh)) begin
          ok = (c == 2'd0) ? m_rwx[i][0] : (c == 2'd1) ? m_rwx[i][1] : m_rwx[i][2];
          if (!ok) pf = 1'b1;
          else begin
            mask = (56'd1 << (12 + sh)) - 56'd1;
            pa = ({m_ppn[i], 12'h000} & ~mask) | (56'(va) & mask);
          end
          return;
        end
      end
    end
    if (m_fv && m_fvpn == vpn) pf = 1'b1;
    else miss = 1'b1;
  endfunction

  task automatic model_refill();
    int victim;
    victim = -1;
    for (int i = ENTRIES - 1; i >= 0; i--) if (!m_v[i]) victim = i;
    if (victim < 0) begin
      victim = m_rr;
      m_rr = (m_rr + 1) % ENTRIES;
    end
    m_v[victim] = 1'b1;
    m_vpn[victim] = m_wvpn;
    m_ppn[victim] = pte[53:10];
    m_lvl[victim] = int'(resp_level);
    m_rwx[victim] = pte[3:1];
    if (m_fv && m_fvpn == m_wvpn) m_fv = 1'b0;
  endtask

  task automatic model_step(input bit lk_miss);
    bit good;
    case (m_st)
      0: if (lk_miss) begin m_st = 1; m_wvpn = vaddr[38:12]; end
      1: begin
        if (sfence) m_st = 0;
        else if (ready) m_st = 2;
      end
      default: begin
        if (resp_valid) begin
          if (!m_kill && !sfence) begin
            good = pte[0] && (pte[3:1] != 3'b000) && !(pte[2] && !pte[1]);
            if (good) model_refill();
            else begin m_fv = 1'b1; m_fvpn = m_wvpn; end
          end
          m_kill = 1'b0;
          m_st = 0;
        end else if (sfence) m_kill = 1'b1;
      end
    endcase
    if (sfence) begin
      for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
      m_fv = 1'b0;
    end
  endtask

  // One clock: predict, advance the model, let the DUT clock, then score.
  task automatic cycle();
    bit miss, pf;
    logic [55:0] pa;
    logic [58:0] e;
    if (req_valid) model_lookup(vaddr, cmd, trans_en, miss, pf, pa);
    else begin miss = 1'b0; pf = 1'b0; pa = '0; end
    exp_q.push_back({req_valid, miss, pf, pa});
    model_step(miss);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check_eq("resp_valid", o_resp_valid, e[58]);
    check_eq("resp_miss", o_resp_miss, e[57]);
    check_eq("resp_pf", o_resp_pf, e[56]);
    if (e[58] && !e[57] && !e[56]) check_eq("resp_paddr", o_resp_paddr, e[55:0]);
    check_eq("ptw_req_valid", o_ptw_req_valid, (m_st == 1));
    if (m_st == 1) check_eq("ptw_req_vpn", o_ptw_req_vpn, m_wvpn);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    req_valid = 1'b0; sfence = 1'b0; ready = 1'b0; resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_eq("rst_resp_valid", o_resp_valid, 0);
    check_eq("rst_resp_miss", o_resp_miss, 0);
    check_eq("rst_resp_pf", o_resp_pf, 0);
    check_eq("rst_resp_paddr", o_resp_paddr, 0);
    check_eq("rst_ptw_valid", o_ptw_req_valid, 0);
    check_eq("rst_ptw_vpn", o_ptw_req_vpn, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic lookup(input logic [38:0] va, input logic [1:0] c);
    req_valid = 1'b1; vaddr = va; cmd = c;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic accept();
    ready = 1'b1; cycle(); ready = 1'b0;
  endtask

  task automatic respond(input logic [43:0] ppn, input logic [2:0] rwx, input bit v, input logic [1:0] lvl);
    pte = {10'h0, ppn, 6'h0, rwx, v};
    resp_level = lvl;
    resp_valid = 1'b1; cycle(); resp_valid = 1'b0;
  endtask

  task automatic do_sfence();
    sfence = 1'b1; cycle(); sfence = 1'b0;
  endtask

  task automatic walk(input logic [38:0] va, input logic [43:0] ppn, input logic [2:0] rwx, input logic [1:0] lvl);
    lookup(va, 2'd0);
    accept();
    respond(ppn, rwx, 1'b1, lvl);
  endtask

  logic [26:0] pool [12];

  initial begin
    model_reset();
    do_reset();
    cycle();

    // basic walk and hit
    lookup(39'h1234, 2'd0);
    check_eq("basic_miss", o_resp_miss, 1);
    check_eq("basic_walk_vpn", o_ptw_req_vpn, 27'h1);
    accept();
    respond(44'h80000, 3'b001, 1'b1, 2'd0);
    lookup(39'h1234, 2'd0);
    check_eq("basic_paddr", o_resp_paddr, 56'h8000_0234);

    // 2 MiB superpage
    walk(39'h20_5678, 44'h80200, 3'b001, 2'd1);
    lookup(39'h20_5678, 2'd0);
    check_eq("super_paddr", o_resp_paddr, 56'h8020_5678);
    lookup(39'h3F_FFF0, 2'd0);
    check_eq("super_paddr2", o_resp_paddr, 56'h803F_FFF0);
    check_eq("super_no_walk", o_ptw_req_valid, 0);

    // faults: invalid PTE, store to read-only leaf, sfence clears the fault
    lookup(39'h5000, 2'd0);
    accept();
    respond(44'h123, 3'b001, 1'b0, 2'd0);
    lookup(39'h5000, 2'd0);
    check_eq("fault_pf", o_resp_pf, 1);
    check_eq("fault_nomiss", o_resp_miss, 0);
    walk(39'h6000, 44'h456, 3'b001, 2'd0);
    lookup(39'h6010, 2'd1);
    check_eq("store_ro_pf", o_resp_pf, 1);
    do_sfence();
    lookup(39'h5000, 2'd0);
    check_eq("sfence_miss", o_resp_miss, 1);
    check_eq("sfence_rewalk", o_ptw_req_valid, 1);
    accept();
    respond(44'h777, 3'b011, 1'b1, 2'd0);

    // replacement: fill all entries, then two more evict entries 0 and 1
    do_sfence();
    for (int k = 0; k < 10; k++) walk({27'(32'h100 + k), 12'h0}, 44'(32'h9000 + k), 3'b111, 2'd0);
    lookup({27'h102, 12'h8}, 2'd2);
    check_eq("repl_keep_hit", o_resp_miss, 0);
    lookup({27'h100, 12'h8}, 2'd0);
    check_eq("repl_evict0", o_resp_miss, 1);
    lookup({27'h101, 12'h8}, 2'd0);
    check_eq("repl_evict1", o_resp_miss, 1);
    accept();
    respond(44'h9100, 3'b001, 1'b1, 2'd0);

    // sfence while waiting for the PTE: the response writes nothing
    lookup({27'h200, 12'h0}, 2'd0);
    accept();
    do_sfence();
    respond(44'hABC, 3'b001, 1'b1, 2'd0);
    check_eq("kill_idle", o_dbg_state, 0);
    lookup({27'h200, 12'h0}, 2'd0);
    check_eq("kill_miss", o_resp_miss, 1);
    check_eq("kill_rewalk_vpn", o_ptw_req_vpn, 27'h200);
    accept();
    respond(44'hABC, 3'b001, 1'b1, 2'd0);

    // second miss during a walk starts nothing
    lookup({27'h300, 12'h0}, 2'd0);
    accept();
    lookup({27'h301, 12'h0}, 2'd0);
    check_eq("busy_miss", o_resp_miss, 1);
    check_eq("busy_no_req", o_ptw_req_valid, 0);
    respond(44'hDEF, 3'b001, 1'b1, 2'd0);

    // bare mode
    trans_en = 1'b0;
    lookup(39'h7F_1234_5678, 2'd2);
    check_eq("bare_paddr", o_resp_paddr, 56'h7F_1234_5678);
    check_eq("bare_no_walk", o_ptw_req_valid, 0);
    trans_en = 1'b1;

    // reset mid-walk: the late response is ignored
    lookup({27'h400, 12'h0}, 2'd0);
    accept();
    do_reset();
    respond(44'h111, 3'b001, 1'b1, 2'd0);
    lookup(39'h1234, 2'd0);
    check_eq("post_reset_miss", o_resp_miss, 1);

    // random traffic over a small VPN pool (distinct gigapage fields)
    do_reset();
    for (int i = 0; i < 12; i++) pool[i] = {9'(i * 37 + 3), 18'($urandom)};
    for (int n = 0; n < 3000; n++) begin
      req_valid  = ($urandom_range(0, 9) < 7);
      vaddr      = {pool[$urandom_range(0, 11)], 12'($urandom)};
      cmd        = 2'($urandom_range(0, 2));
      trans_en   = ($urandom_range(0, 19) != 0);
      sfence     = ($urandom_range(0, 49) == 0);
      ready      = 1'($urandom_range(0, 1));
      resp_valid = (m_st == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      pte        = {10'h0, 44'({$urandom, $urandom}), 6'h0, 3'($urandom), ($urandom_range(0, 9) != 0)};
      resp_level = 2'($urandom_range(0, 2));
      cycle();
    end
    idle_in();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
